// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared occupancy encodings and pipeline control-bundle layout
package pipe_pkg;

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_FULL  = 2'd2;

    // Stage state doubles as the occupancy value driven on the port.
    typedef enum logic [1:0] {
        ST_EMPTY = OCC_EMPTY,
        ST_ONE   = OCC_ONE,
        ST_FULL  = OCC_FULL
    } occ_state_e;

    // Default control-bundle widths for the per-stage registers.
    localparam int IDEX_CTRL_W  = 16;
    localparam int EXMEM_CTRL_W = 8;
    localparam int MEMWB_CTRL_W = 8;

    // Field offsets inside the ID/EX control bundle.
    localparam int CTRL_MEMRW_BIT  = 0;
    localparam int CTRL_REGWEN_BIT = 1;
    localparam int CTRL_ASEL_BIT   = 2;
    localparam int CTRL_BSEL_BIT   = 3;
    localparam int CTRL_BRUN_BIT   = 4;
    localparam int CTRL_WBSEL_LSB  = 5;   // 2 bits
    localparam int CTRL_ALUSEL_LSB = 7;   // 4 bits
    localparam int CTRL_RD_LSB     = 11;  // 5 bits

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous active-high clear
// Ports: clk, rst (sync clear), inc (count enable), count (holds at all-ones).
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - elastic pipeline stage with 2-entry skid buffer, flush and stall counter
// Ports: clk, rst (sync, active-high), flush; upstream in_valid/in_ready/in_ctrl/in_data;
//        downstream out_valid/out_ready/out_ctrl/out_data; occupancy (0..2); stall_cnt.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int DATA_W = 128,
    parameter int CTRL_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    occ_state_e        state_q, state_d;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
    logic [DATA_W-1:0] main_data, skid_data;
    logic              in_fire, out_fire;
    logic              load_main_in, load_main_skid, load_skid_in;

    // in_ready looks only at registered state, never at out_ready.
    assign in_ready  = (state_q != ST_FULL) & ~rst;
    assign out_valid = (state_q != ST_EMPTY);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    assign out_ctrl  = out_valid ? main_ctrl : '0;
    assign out_data  = main_data;
    assign occupancy = state_q;

    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid_in   = 1'b0;
        unique case (state_q)
            ST_EMPTY: begin
                if (in_fire) begin
                    state_d      = ST_ONE;
                    load_main_in = 1'b1;
                end
            end
            ST_ONE: begin
                if (in_fire && out_fire) begin
                    load_main_in = 1'b1;
                end else if (in_fire) begin
                    state_d      = ST_FULL;
                    load_skid_in = 1'b1;
                end else if (out_fire) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // Older skid beat moves up; a new beat cannot enter this cycle.
                if (out_fire) begin
                    state_d        = ST_ONE;
                    load_main_skid = 1'b1;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        // Flush kills stored beats and the incoming one.
        if (flush) begin
            state_d        = ST_EMPTY;
            load_main_in   = 1'b0;
            load_main_skid = 1'b0;
            load_skid_in   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_EMPTY;
            main_ctrl <= '0;
            skid_ctrl <= '0;
            main_data <= '0;
            skid_data <= '0;
        end else begin
            state_q <= state_d;
            if (flush) begin
                // Data registers intentionally hold; only control is scrubbed.
                main_ctrl <= '0;
                skid_ctrl <= '0;
            end else begin
                if (load_main_in) begin
                    main_ctrl <= in_ctrl;
                    main_data <= in_data;
                end
                if (load_main_skid) begin
                    main_ctrl <= skid_ctrl;
                    main_data <= skid_data;
                end
                if (load_skid_in) begin
                    skid_ctrl <= in_ctrl;
                    skid_data <= in_data;
                end
            end
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (out_valid & ~out_ready),
        .count (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb/tb_pipe_stage_skid.sv - self-checking bench for pipe_stage_skid against a queue model
module tb_pipe_stage_skid;

    localparam int DW = 32;
    localparam int CW = 16;
    localparam int NW = 4;

    logic          clk = 1'b0;
    logic          rst, flush, in_valid, out_ready;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;
    logic          in_ready, out_valid;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;
    logic [1:0]    occupancy;
    logic [NW-1:0] stall_cnt;

    always #5 clk = ~clk;

    pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .occupancy (occupancy),
        .stall_cnt (stall_cnt)
    );

    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } beat_t;

    beat_t   q[$];
    logic [DW-1:0] head_data;
    int      m_cnt;
    bit      known = 1'b0;
    int      passes = 0;
    int      total = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One clock: drive at negedge, compare just after, advance the model for the next rising edge.
    task automatic cyc(input logic r, input logic f, input logic iv,
                       input logic [CW-1:0] c, input logic [DW-1:0] d, input logic ordy);
        bit exp_ready, ifire, ofire;
        @(negedge clk);
        rst = r; flush = f; in_valid = iv; in_ctrl = c; in_data = d; out_ready = ordy;
        #1;
        exp_ready = !r && (q.size() < 2);
        if (known) begin
            check("in_ready",  64'(in_ready),  64'(exp_ready));
            check("out_valid", 64'(out_valid), 64'(q.size() > 0));
            check("out_ctrl",  64'(out_ctrl),  (q.size() > 0) ? 64'(q[0].c) : 64'd0);
            check("out_data",  64'(out_data),  64'(head_data));
            check("occupancy", 64'(occupancy), 64'(q.size()));
            check("stall_cnt", 64'(stall_cnt), 64'(m_cnt));
        end
        if (r) begin
            q.delete();
            head_data = '0;
            m_cnt = 0;
            known = 1'b1;
        end else begin
            ifire = iv && exp_ready;
            ofire = (q.size() > 0) && ordy;
            if ((q.size() > 0) && !ordy && m_cnt < (1 << NW) - 1) m_cnt++;
            if (f) begin
                q.delete();
            end else begin
                if (ofire) void'(q.pop_front());
                if (ifire) q.push_back('{c: c, d: d});
                if (q.size() > 0) head_data = q[0].d;
            end
        end
        @(posedge clk);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_ctrl = '0; in_data = '0; out_ready = 1'b0;
        head_data = '0; m_cnt = 0;

        // Reset held two cycles with a beat offered.
        cyc(1, 0, 1, 16'h1234, 32'hdead, 0);
        cyc(1, 0, 1, 16'h1234, 32'hdead, 0);
        cyc(0, 0, 0, 16'h0, 32'h0, 1);

        // Streaming with downstream always ready.
        for (int i = 1; i <= 4; i++) cyc(0, 0, 1, 16'(i + 16'h10), 32'(i), 1);
        cyc(0, 0, 0, 16'h0, 32'h0, 1);
        cyc(0, 0, 0, 16'h0, 32'h0, 1);

        // Backpressure fills the skid entry, then drains in order.
        cyc(0, 0, 1, 16'h00aa, 32'ha, 0);
        cyc(0, 0, 1, 16'h00bb, 32'hb, 0);
        cyc(0, 0, 1, 16'h00cc, 32'hc, 0);
        cyc(0, 0, 0, 16'h0, 32'h0, 0);
        cyc(0, 0, 0, 16'h0, 32'h0, 1);
        cyc(0, 0, 0, 16'h0, 32'h0, 1);
        cyc(0, 0, 0, 16'h0, 32'h0, 1);

        // Flush while full, with a beat offered in the flush cycle.
        cyc(0, 0, 1, 16'hffff, 32'h11, 0);
        cyc(0, 0, 1, 16'hffff, 32'h22, 0);
        cyc(0, 1, 1, 16'h00cc, 32'hc, 0);
        cyc(0, 0, 0, 16'h0, 32'h0, 1);
        cyc(0, 0, 0, 16'h0, 32'h0, 1);

        // Stall counter saturation, then reset clears it.
        cyc(1, 0, 0, 16'h0, 32'h0, 0);
        cyc(0, 0, 1, 16'h0077, 32'h77, 0);
        for (int i = 0; i < 20; i++) cyc(0, 0, 0, 16'h0, 32'h0, 0);
        cyc(1, 0, 0, 16'h0, 32'h0, 0);
        cyc(0, 0, 0, 16'h0, 32'h0, 1);

        // Reset beats flush and a valid beat while full.
        cyc(0, 0, 1, 16'h0101, 32'h101, 0);
        cyc(0, 0, 1, 16'h0202, 32'h202, 0);
        cyc(1, 1, 1, 16'h0303, 32'h303, 0);
        cyc(0, 0, 0, 16'h0, 32'h0, 1);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 59) == 0), ($urandom_range(0, 9) == 0),
                ($urandom_range(0, 9) < 6), 16'($urandom), 32'($urandom),
                ($urandom_range(0, 9) < 6));
        end
        cyc(0, 0, 0, 16'h0, 32'h0, 1);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
